// File: rtl/scmi_doorbell_arbiter.sv
// SCMI doorbell arbiter: latches doorbell rising edges per channel, round-robin
// picks one eligible channel at a time and notifies the core through a level
// irq with ack handshake; tracks in-service channels until firmware completion.
// Optional ack timeout is compiled in with `define SCMI_DB_ACK_TIMEOUT_EN.

// Per-channel state: edge detect, pending and in-service bits.
module scmi_db_ch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic db,       // raw doorbell line
  input  logic en,       // channel mask bit
  input  logic claim,    // core acked this channel
  input  logic retire,   // firmware completed this channel
  output logic pend,
  output logic busy,
  output logic overrun   // combinational: accepted rise while pending/busy
);
  logic db_q;
  logic rise;

  assign rise    = db & ~db_q & en;
  assign overrun = rise & (pend | busy);

  // Edge register plus pending/in-service bits; ack set beats completion clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      db_q <= 1'b0;
      pend <= 1'b0;
      busy <= 1'b0;
    end else begin
      db_q <= db;
      pend <= (pend & ~claim) | (rise & ~pend & ~busy);
      busy <= (busy & ~retire) | claim;
    end
  end
endmodule

module scmi_doorbell_arbiter #(
  parameter  int NUM_CH         = 256,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] db_irq_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic              irq_o,
  output logic [ID_W-1:0]   irq_id_o,
  input  logic              irq_ack_i,
  input  logic              done_valid_i,
  input  logic [ID_W-1:0]   done_id_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] in_service_o,
  output logic              overrun_o,
  output logic [ID_W-1:0]   overrun_id_o,
  output logic              timeout_o
);
  typedef enum logic {IDLE, NOTIFY} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   grant, grant_nxt;
  logic [ID_W-1:0]   last_grant, last_grant_nxt;
  logic              irq_nxt;
  logic              take;
  logic              expire;
  logic [NUM_CH-1:0] claim, retire, ov_vec, eligible;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic [ID_W-1:0]   ov_id;

  assign eligible = pending_o & ch_mask_i & ~in_service_o;
  assign irq_id_o = grant;

  // Per-channel cells; claim/retire are one-hot decodes of grant/done_id.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign claim[c]  = take && (grant == ID_W'(c));
    assign retire[c] = done_valid_i && (done_id_i == ID_W'(c));
    scmi_db_ch u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .db      (db_irq_i[c]),
      .en      (ch_mask_i[c]),
      .claim   (claim[c]),
      .retire  (retire[c]),
      .pend    (pending_o[c]),
      .busy    (in_service_o[c]),
      .overrun (ov_vec[c])
    );
  end

  // Round-robin search: first eligible index after last_grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = int'(last_grant) + 1 + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Lowest-indexed overrun channel.
  always_comb begin
    ov_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (ov_vec[i]) ov_id = ID_W'(i);
  end

`ifdef SCMI_DB_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;

  // Ack timeout counter: zero on NOTIFY entry, counts unacked NOTIFY cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= expire;
      if (state == IDLE)   to_cnt <= '0;
      else if (!irq_ack_i) to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_o      = 1'b0;
`endif

  // FSM next state and grant bookkeeping; ack wins over timeout expiry.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    irq_nxt        = irq_o;
    take           = 1'b0;
    expire         = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          irq_nxt   = 1'b1;
          state_nxt = NOTIFY;
        end
      end
      NOTIFY: begin
        if (irq_ack_i) begin
          take           = 1'b1;
          last_grant_nxt = grant;
          irq_nxt        = 1'b0;
          state_nxt      = IDLE;
        end
`ifdef SCMI_DB_ACK_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          expire         = 1'b1;
          last_grant_nxt = grant;
          irq_nxt        = 1'b0;
          state_nxt      = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant, irq and overrun registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= ID_W'(NUM_CH - 1);
      irq_o        <= 1'b0;
      overrun_o    <= 1'b0;
      overrun_id_o <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      last_grant   <= last_grant_nxt;
      irq_o        <= irq_nxt;
      overrun_o    <= |ov_vec;
      overrun_id_o <= ov_id;
    end
  end
endmodule

// File: tb/tb_scmi_doorbell_arbiter.sv
// Scoreboard bench for scmi_doorbell_arbiter: expected notification IDs are
// queued when doorbells are driven and checked when irq_o comes up.
module tb_scmi_doorbell_arbiter;
  localparam int NUM_CH = 256;
  localparam int ID_W   = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NUM_CH-1:0] db_irq_i, ch_mask_i, pending_o, in_service_o;
  logic              irq_o, irq_ack_i, done_valid_i, overrun_o, timeout_o;
  logic [ID_W-1:0]   irq_id_o, done_id_i, overrun_id_o;

  int                n_chk  = 0;
  int                n_fail = 0;
  int                sb[$];
  logic [NUM_CH-1:0] exp_isv;

  always #5 clk_i = ~clk_i;

  scmi_doorbell_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .db_irq_i(db_irq_i), .ch_mask_i(ch_mask_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i),
    .done_valid_i(done_valid_i), .done_id_i(done_id_i),
    .pending_o(pending_o), .in_service_o(in_service_o),
    .overrun_o(overrun_o), .overrun_id_o(overrun_id_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Wait for a notification, compare against the scoreboard, then ack it.
  task automatic serve(input bit with_done);
    int n = 0;
    int exp;
    while (irq_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (irq_o !== 1'b1) begin
      chk("irq_wait", irq_o, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    exp = sb.pop_front();
    chk("irq_id", irq_id_o, exp);
    irq_ack_i = 1'b1;
    if (with_done) begin
      done_valid_i = 1'b1;
      done_id_i    = ID_W'(exp);
    end
    tick();
    irq_ack_i    = 1'b0;
    done_valid_i = 1'b0;
    exp_isv[exp] = 1'b1;
    chk("irq_drop", irq_o, 0);
    chk("pend_clr", pending_o[exp], 0);
    chk("isv_map", in_service_o, exp_isv);
  endtask

  task automatic do_done(input int id);
    done_valid_i = 1'b1;
    done_id_i    = ID_W'(id);
    tick();
    done_valid_i = 1'b0;
    exp_isv[id]  = 1'b0;
    chk("isv_done", in_service_o, exp_isv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; db_irq_i = '0; ch_mask_i = '1; irq_ack_i = 1'b0;
    done_valid_i = 1'b0; done_id_i = '0; exp_isv = '0;
    tick(); tick();
    chk("rst_irq", irq_o, 0);
    chk("rst_pend", pending_o, 0);
    chk("rst_isv", in_service_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_to", timeout_o, 0);
    rst_ni = 1'b1;
    tick();

    // Basic latency on channel 0.
    db_irq_i[0] = 1'b1;
    tick();
    chk("lat_pend", pending_o[0], 1);
    chk("lat_irq_lo", irq_o, 0);
    tick();
    chk("lat_irq_hi", irq_o, 1);
    sb.push_back(0);
    serve(0);

    // Round-robin from last_grant=5.
    db_irq_i[5] = 1'b1; sb.push_back(5);
    serve(0);
    db_irq_i[3] = 1'b1; db_irq_i[7] = 1'b1; db_irq_i[250] = 1'b1;
    sb.push_back(7); sb.push_back(250); sb.push_back(3);
    serve(0); serve(0); serve(0);

    // Overrun on an in-service channel.
    db_irq_i[3] = 1'b0; tick();
    db_irq_i[3] = 1'b1; tick();
    chk("ovr_pulse", overrun_o, 1);
    chk("ovr_id", overrun_id_o, 3);
    tick();
    chk("ovr_end", overrun_o, 0);
    repeat (4) tick();
    chk("ovr_noirq", irq_o, 0);
    db_irq_i[7] = 1'b0; db_irq_i[250] = 1'b0; tick();
    db_irq_i[7] = 1'b1; db_irq_i[250] = 1'b1; tick();
    chk("ovr_lowest", overrun_id_o, 7);
    do_done(3);
    db_irq_i[3] = 1'b0; tick();
    db_irq_i[3] = 1'b1; sb.push_back(3);
    serve(0);

    // Masking: ignored rise, then a frozen pending channel.
    ch_mask_i[4] = 1'b0; db_irq_i[4] = 1'b1;
    tick(); tick();
    chk("mask_nopend", pending_o[4], 0);
    chk("mask_noirq", irq_o, 0);
    ch_mask_i[4] = 1'b1;
    repeat (3) tick();
    chk("unmask_noirq", irq_o, 0);
    do_done(5);
    db_irq_i[5] = 1'b0; tick();
    db_irq_i[5] = 1'b1; tick();
    ch_mask_i[5] = 1'b0;
    repeat (5) tick();
    chk("frz_pend", pending_o[5], 1);
    chk("frz_noirq", irq_o, 0);
    ch_mask_i[5] = 1'b1; sb.push_back(5);
    serve(0);

    // Same-cycle ack and done, then done on an idle channel.
    db_irq_i[9] = 1'b1; sb.push_back(9);
    serve(1);
    chk("ackdone_isv9", in_service_o[9], 1);
    do_done(12);
    chk("pend_quiet", pending_o, 0);

`ifndef SCMI_DB_ACK_TIMEOUT_EN
    // No timeout: irq holds indefinitely.
    db_irq_i[20] = 1'b1; sb.push_back(20);
    tick(); tick();
    chk("hold_start", irq_o, 1);
    repeat (40) tick();
    chk("hold_irq", irq_o, 1);
    chk("hold_to", timeout_o, 0);
    serve(0);
`else
    begin
      int pulses = 0;
      db_irq_i[20] = 1'b1; sb.push_back(20);
      repeat (1100) begin
        tick();
        if (timeout_o === 1'b1) pulses++;
      end
      chk("to_pulses", pulses, 1);
      chk("to_pend", pending_o[20], 1);
      serve(0);
    end
`endif

    // Reset during NOTIFY drops irq_o.
    db_irq_i[30] = 1'b1;
    tick(); tick();
    chk("mid_irq", irq_o, 1);
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_irq", irq_o, 0);
    chk("mid_rst_pend", pending_o, 0);
    chk("mid_rst_isv", in_service_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
